// File: rtl/audio_frame_writer_if.sv
// AXI4-Lite write-only channel bundle between audio_frame_writer (master)
// and the AXI_to_audio register file (slave).
//   awaddr/awvalid/awready : write address channel
//   wdata/wstrb/wvalid/wready : write data channel
//   bresp/bvalid/bready : write response channel
interface audio_frame_writer_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/audio_frame_writer.sv
// audio_frame_writer: on each enabled sample tick, writes one stereo frame
// (left, right, frame-count commit) into the AXI_to_audio register file over
// an AXI4-Lite write-only master.
//   ACLK, ARESETN        : clock, asynchronous active-low reset
//   enable, sample_tick  : tick gating and sample-rate strobe
//   s_valid/s_ready/s_left/s_right : input sample-pair stream
//   m_axi                : AXI4-Lite write master (audio_frame_writer_if)
//   busy                 : frame in progress
//   underrun, tick_miss  : one-cycle status pulses
//   err_count            : saturating count of non-OKAY write responses
//   frame_count          : completed frames, wraps
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an enabled tick; hold register may fill
// SEND  | awvalid/wvalid up, each dropped after its own handshake
// RESP  | bready up, waiting for the write response of current phase
module audio_frame_writer #(
    parameter int                          C_M_AXI_ADDR_WIDTH = 32,
    parameter int                          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
    parameter int                          SAMPLE_WIDTH       = 16,
    // reset value of frame_count; normally zero
    parameter logic [31:0]                 FRAME_COUNT_INIT   = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    enable,
    input  logic                    sample_tick,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_left,
    input  logic [SAMPLE_WIDTH-1:0] s_right,
    audio_frame_writer_if.master    m_axi,
    output logic                    busy,
    output logic                    underrun,
    output logic                    tick_miss,
    output logic [7:0]              err_count,
    output logic [31:0]             frame_count
);

    if (C_M_AXI_DATA_WIDTH != 32 || SAMPLE_WIDTH < 1 || SAMPLE_WIDTH > 32) begin : g_param_check
        $error("audio_frame_writer: data width must be 32 and sample width 1..32");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RESP
    } state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    phase_q, phase_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [31:0]                   wdata_q, wdata_d;
    logic [31:0]                   right_q, right_d;
    logic                          hold_full_q, hold_full_d;
    logic [SAMPLE_WIDTH-1:0]       hold_l_q, hold_l_d;
    logic [SAMPLE_WIDTH-1:0]       hold_r_q, hold_r_d;
    logic [7:0]                    err_q, err_d;
    logic [31:0]                   frame_q, frame_d;
    logic                          underrun_q, underrun_d;
    logic                          tick_miss_q, tick_miss_d;
    logic                          tick_go;
    logic [SAMPLE_WIDTH-1:0]       src_l, src_r;

    function automatic logic [31:0] sext(input logic [SAMPLE_WIDTH-1:0] x);
        return 32'(signed'(x));
    endfunction

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            right_q     <= '0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            err_q       <= '0;
            frame_q     <= FRAME_COUNT_INIT;
            underrun_q  <= 1'b0;
            tick_miss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            right_q     <= right_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            err_q       <= err_d;
            frame_q     <= frame_d;
            underrun_q  <= underrun_d;
            tick_miss_q <= tick_miss_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        right_d     = right_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        err_d       = err_q;
        frame_d     = frame_q;
        underrun_d  = 1'b0;
        tick_miss_d = 1'b0;
        src_l       = '0;
        src_r       = '0;

        tick_go = sample_tick && enable && (state_q == ST_IDLE);

        // A pair offered in the same cycle as an accepted tick is consumed by
        // the frame directly, so it must not also land in the hold register.
        if (s_valid && !hold_full_q && !tick_go) begin
            hold_full_d = 1'b1;
            hold_l_d    = s_left;
            hold_r_d    = s_right;
        end

        if (sample_tick && enable && (state_q != ST_IDLE)) begin
            tick_miss_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick_go) begin
                    if (hold_full_q) begin
                        src_l       = hold_l_q;
                        src_r       = hold_r_q;
                        hold_full_d = 1'b0;
                    end else if (s_valid) begin
                        src_l = s_left;
                        src_r = s_right;
                    end else begin
                        underrun_d = 1'b1;
                    end
                    state_d   = ST_SEND;
                    phase_d   = 2'd0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = BASE_ADDR;
                    wdata_d   = sext(src_l);
                    right_d   = sext(src_r);
                end
            end
            ST_SEND: begin
                awvalid_d = awvalid_q && !m_axi.awready;
                wvalid_d  = wvalid_q && !m_axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_axi.bvalid) begin
                    if (m_axi.bresp != 2'b00 && err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (phase_q == 2'd2) begin
                        state_d = ST_IDLE;
                        frame_d = frame_q + 32'd1;
                    end else begin
                        phase_d   = phase_q + 2'd1;
                        state_d   = ST_SEND;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({phase_d, 2'b00});
                        // commit word carries the count before this frame completes
                        wdata_d   = (phase_q == 2'd0) ? right_q : frame_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s_ready       = !hold_full_q;
    assign busy          = (state_q != ST_IDLE);
    assign underrun      = underrun_q;
    assign tick_miss     = tick_miss_q;
    assign err_count     = err_q;
    assign frame_count   = frame_q;

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = (state_q == ST_RESP);

endmodule

// File: tb/tb_audio_frame_writer.sv
// Directed bench for audio_frame_writer: a responding AXI4-Lite slave model
// logs every write; a second instance starts its frame counter near wrap.
module tb_audio_frame_writer;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        sample_tick;
    logic        s_valid;
    logic [15:0] s_left, s_right;
    logic        s_ready, busy, underrun, tick_miss;
    logic [7:0]  err_count;
    logic [31:0] frame_count;

    logic        tick2;
    logic        s_ready2, busy2, underrun2, tick_miss2;
    logic [7:0]  err_count2;
    logic [31:0] frame_count2;

    logic        awready_drv;
    logic [3:0]  err_mask;
    logic [31:0] last_awaddr;
    logic        aw_got, w_got;
    int          aw_n = 0;
    int          w_n = 0;
    logic [31:0] aw_log [0:1023];
    logic [31:0] w_log  [0:1023];

    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;

    audio_frame_writer_if bus ();
    audio_frame_writer_if bus2 ();

    audio_frame_writer #(.BASE_ADDR(BASE)) dut (
        .ACLK(aclk), .ARESETN(aresetn), .enable(enable), .sample_tick(sample_tick),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .m_axi(bus), .busy(busy), .underrun(underrun), .tick_miss(tick_miss),
        .err_count(err_count), .frame_count(frame_count)
    );

    audio_frame_writer #(.BASE_ADDR(BASE), .FRAME_COUNT_INIT(32'hFFFF_FFFE)) dut2 (
        .ACLK(aclk), .ARESETN(aresetn), .enable(enable), .sample_tick(tick2),
        .s_valid(1'b0), .s_ready(s_ready2), .s_left(16'h0), .s_right(16'h0),
        .m_axi(bus2), .busy(busy2), .underrun(underrun2), .tick_miss(tick_miss2),
        .err_count(err_count2), .frame_count(frame_count2)
    );

    // slave model for dut: awready from the stimulus, wready always high,
    // bvalid one cycle after both handshakes, bresp chosen per register slot
    wire aw_hs = bus.awvalid && bus.awready;
    wire w_hs  = bus.wvalid && bus.wready;
    assign bus.awready = awready_drv;
    assign bus.wready  = 1'b1;
    assign bus.bresp   = err_mask[last_awaddr[3:2]] ? 2'b10 : 2'b00;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.bvalid  <= 1'b0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            last_awaddr <= '0;
        end else begin
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (aw_hs) begin
                aw_log[aw_n[9:0]] <= bus.awaddr;
                aw_n              <= aw_n + 1;
                last_awaddr       <= bus.awaddr;
            end
            if (w_hs) begin
                w_log[w_n[9:0]] <= bus.wdata;
                w_n             <= w_n + 1;
            end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                bus.bvalid <= 1'b1;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
        end
    end

    // zero-wait slave for dut2
    assign bus2.awready = 1'b1;
    assign bus2.wready  = 1'b1;
    assign bus2.bresp   = 2'b00;
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                       bus2.bvalid <= 1'b0;
        else if (bus2.bvalid && bus2.bready) bus2.bvalid <= 1'b0;
        else if (bus2.awvalid)              bus2.bvalid <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_with(input logic v, input logic [15:0] l, input logic [15:0] r);
        @(negedge aclk);
        sample_tick = 1'b1;
        s_valid     = v;
        s_left      = l;
        s_right     = r;
        @(negedge aclk);
        sample_tick = 1'b0;
        s_valid     = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            @(negedge aclk);
            cycles++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic check_frame(input string tag, input int ab, input int wb,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2);
        check({tag, "_nwrites"}, aw_n - ab, 3);
        check({tag, "_addr0"}, aw_log[ab[9:0]], BASE);
        check({tag, "_addr1"}, aw_log[10'(ab + 1)], BASE + 32'd4);
        check({tag, "_addr2"}, aw_log[10'(ab + 2)], BASE + 32'd8);
        check({tag, "_data0"}, w_log[wb[9:0]], d0);
        check({tag, "_data1"}, w_log[10'(wb + 1)], d1);
        check({tag, "_data2"}, w_log[10'(wb + 2)], d2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ab, wb, cyc;
        aresetn     = 1'b0;
        enable      = 1'b0;
        sample_tick = 1'b0;
        s_valid     = 1'b0;
        s_left      = '0;
        s_right     = '0;
        tick2       = 1'b0;
        awready_drv = 1'b1;
        err_mask    = 4'b0000;

        #12;
        check("rst_awvalid", bus.awvalid, 1'b0);
        check("rst_wvalid", bus.wvalid, 1'b0);
        check("rst_bready", bus.bready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_tick_miss", tick_miss, 1'b0);
        check("rst_err_count", err_count, 8'd0);
        check("rst_frame_count", frame_count, 32'd0);
        check("rst_awaddr", bus.awaddr, 32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        check("rst_s_ready", s_ready, 1'b1);
        check("wstrb", bus.wstrb, 4'hF);

        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // tick with enable low is ignored
        tick_with(1'b0, 16'h0, 16'h0);
        check("dis_busy", busy, 1'b0);
        check("dis_underrun", underrun, 1'b0);
        check("dis_tick_miss", tick_miss, 1'b0);

        // frame from the hold register, zero-wait slave
        enable = 1'b1;
        @(negedge aclk);
        s_valid = 1'b1; s_left = 16'h1234; s_right = 16'h8001;
        @(negedge aclk);
        s_valid = 1'b0;
        check("hold_s_ready", s_ready, 1'b0);
        ab = aw_n; wb = w_n;
        tick_with(1'b0, 16'h0, 16'h0);
        check("t1_valids", {bus.awvalid, bus.wvalid}, 2'b11);
        check("t1_underrun", underrun, 1'b0);
        check("t1_s_ready", s_ready, 1'b1);
        wait_idle("t1_idle", cyc);
        check("t1_busy_cycles", cyc, 6);
        check("t1_frame_count", frame_count, 32'd1);
        check_frame("t1", ab, wb, 32'h0000_1234, 32'hFFFF_8001, 32'd0);

        // no sample: silence and underrun pulse
        ab = aw_n; wb = w_n;
        tick_with(1'b0, 16'h0, 16'h0);
        check("t2_underrun", underrun, 1'b1);
        @(negedge aclk);
        check("t2_underrun_pulse", underrun, 1'b0);
        wait_idle("t2_idle", cyc);
        check_frame("t2", ab, wb, 32'd0, 32'd0, 32'd1);

        // sample offered in the tick cycle is bypassed
        ab = aw_n; wb = w_n;
        tick_with(1'b1, 16'h0005, 16'h0006);
        check("t3_underrun", underrun, 1'b0);
        wait_idle("t3_idle", cyc);
        check("t3_s_ready", s_ready, 1'b1);
        check_frame("t3", ab, wb, 32'd5, 32'd6, 32'd2);

        // awready low 3 cycles, wready immediate
        ab = aw_n; wb = w_n;
        @(negedge aclk);
        awready_drv = 1'b0;
        sample_tick = 1'b1; s_valid = 1'b1; s_left = 16'hFFFE; s_right = 16'h7FFF;
        @(negedge aclk);
        sample_tick = 1'b0; s_valid = 1'b0;
        check("t4_valids", {bus.awvalid, bus.wvalid}, 2'b11);
        @(negedge aclk);
        check("t4_wvalid_dropped", bus.wvalid, 1'b0);
        check("t4_awvalid_held1", bus.awvalid, 1'b1);
        check("t4_awaddr1", bus.awaddr, BASE);
        @(negedge aclk);
        check("t4_awvalid_held2", bus.awvalid, 1'b1);
        check("t4_awaddr2", bus.awaddr, BASE);
        check("t4_bready", bus.bready, 1'b0);
        @(negedge aclk);
        check("t4_awvalid_held3", bus.awvalid, 1'b1);
        awready_drv = 1'b1;
        wait_idle("t4_idle", cyc);
        check("t4_frame_count", frame_count, 32'd4);
        check_frame("t4", ab, wb, 32'hFFFF_FFFE, 32'h0000_7FFF, 32'd3);

        // SLVERR on the right-sample write only
        err_mask = 4'b0010;
        ab = aw_n; wb = w_n;
        tick_with(1'b0, 16'h0, 16'h0);
        wait_idle("t5_idle", cyc);
        check("t5_err_count", err_count, 8'd1);
        check_frame("t5", ab, wb, 32'd0, 32'd0, 32'd4);

        // 300 more errors: saturate at 255
        err_mask = 4'b0111;
        for (int i = 0; i < 100; i++) begin
            tick_with(1'b0, 16'h0, 16'h0);
            wait_idle("t6_idle", cyc);
            if (i == 83) check("t6_err_253", err_count, 8'd253);
        end
        check("t6_err_sat", err_count, 8'd255);
        check("t6_frame_count", frame_count, 32'd105);
        err_mask = 4'b0000;

        // ticks every 4 cycles on dut2: every other tick dropped, count wraps
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            tick2 = 1'b1;
            @(negedge aclk);
            tick2 = 1'b0;
            check("t7_tick_miss", tick_miss2, (i % 2) == 1);
            if (i == 0) check("t7_underrun2", underrun2, 1'b1);
            if (i == 2) check("t7_frame_ffff", frame_count2, 32'hFFFF_FFFF);
            repeat (2) @(negedge aclk);
        end
        cyc = 0;
        while (busy2 && cyc < 200) begin
            @(negedge aclk);
            cyc++;
        end
        check("t7_idle", busy2, 1'b0);
        check("t7_frame_wrap", frame_count2, 32'd0);
        check("t7_err2", err_count2, 8'd0);
        check("t7_s_ready2", s_ready2, 1'b1);

        // reset while stalled in SEND, with the hold register full
        awready_drv = 1'b0;
        tick_with(1'b0, 16'h0, 16'h0);
        s_valid = 1'b1; s_left = 16'hAAAA; s_right = 16'h5555;
        @(negedge aclk);
        s_valid = 1'b0;
        check("t8_hold_full", s_ready, 1'b0);
        check("t8_in_send", bus.awvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        check("t8_awvalid", bus.awvalid, 1'b0);
        check("t8_wvalid", bus.wvalid, 1'b0);
        check("t8_bready", bus.bready, 1'b0);
        check("t8_busy", busy, 1'b0);
        check("t8_s_ready", s_ready, 1'b1);
        check("t8_awaddr", bus.awaddr, 32'd0);
        check("t8_frame_count", frame_count, 32'd0);
        check("t8_err_count", err_count, 8'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        awready_drv = 1'b1;
        @(negedge aclk);
        ab = aw_n; wb = w_n;
        tick_with(1'b0, 16'h0, 16'h0);
        check("t8_underrun", underrun, 1'b1);
        wait_idle("t8_idle", cyc);
        check("t8_busy_cycles", cyc, 6);
        check("t8_frame_after", frame_count, 32'd1);
        check_frame("t8", ab, wb, 32'd0, 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
